// File: rtl/blowfish_feistel.sv
// Blowfish block encryption engine. The 16-round Feistel network is run
// sequentially against an external dual-port SRAM that holds the P-array
// and the four S-boxes. Each round takes six cycles: a P-array read, then
// two paired S-box reads, with every read taking one cycle of latency.
module blowfish_feistel #(
  parameter int P_ARRAY_OFFSET = 4000,
  parameter int SBOX_OFFSET    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] datal,
  input  logic [31:0] datar,
  output logic [31:0] resultl,
  output logic [31:0] resultr,
  output logic        done,
  output logic [11:0] addr_a,
  output logic [11:0] addr_b,
  inout  wire  [31:0] data_a,
  inout  wire  [31:0] data_b,
  output logic        cs_a_l,
  output logic        cs_b_l,
  output logic        oe_a_l,
  output logic        oe_b_l,
  output logic        we_a_l,
  output logic        we_b_l
);

  typedef enum logic [3:0] {
    IDLE, P_RD, P_LAT, S01_RD, S01_LAT, S23_RD, S23_LAT, FIN_RD, FIN_LAT, DONE
  } state_t;

  localparam logic [11:0] P_BASE  = 12'(P_ARRAY_OFFSET);
  localparam logic [11:0] S0_BASE = 12'(SBOX_OFFSET);
  localparam logic [11:0] S1_BASE = 12'(SBOX_OFFSET + 256);
  localparam logic [11:0] S2_BASE = 12'(SBOX_OFFSET + 512);
  localparam logic [11:0] S3_BASE = 12'(SBOX_OFFSET + 768);

  state_t      state;
  state_t      state_next;
  logic [3:0]  round;
  logic [31:0] xl;
  logic [31:0] xr;
  logic [31:0] t;
  logic [31:0] f;

  // This block never writes the SRAM and never drives its data buses.
  assign we_a_l = 1'b1;
  assign we_b_l = 1'b1;

  // Second half of the round function, using the S2/S3 words on the buses.
  assign f = (t ^ data_a) + data_b;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and SRAM port control for the current state.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    cs_a_l     = 1'b1;
    oe_a_l     = 1'b1;
    addr_a     = '0;
    cs_b_l     = 1'b1;
    oe_b_l     = 1'b1;
    addr_b     = '0;
    case (state)
      IDLE: if (start) state_next = P_RD;
      P_RD: begin
        cs_a_l     = 1'b0;
        oe_a_l     = 1'b0;
        addr_a     = P_BASE + {8'd0, round};
        state_next = P_LAT;
      end
      P_LAT: state_next = S01_RD;
      S01_RD: begin
        cs_a_l     = 1'b0;
        oe_a_l     = 1'b0;
        addr_a     = S0_BASE + {4'd0, xl[31:24]};
        cs_b_l     = 1'b0;
        oe_b_l     = 1'b0;
        addr_b     = S1_BASE + {4'd0, xl[23:16]};
        state_next = S01_LAT;
      end
      S01_LAT: state_next = S23_RD;
      S23_RD: begin
        cs_a_l     = 1'b0;
        oe_a_l     = 1'b0;
        addr_a     = S2_BASE + {4'd0, xl[15:8]};
        cs_b_l     = 1'b0;
        oe_b_l     = 1'b0;
        addr_b     = S3_BASE + {4'd0, xl[7:0]};
        state_next = S23_LAT;
      end
      S23_LAT: state_next = (round == 4'd15) ? FIN_RD : P_RD;
      FIN_RD: begin
        cs_a_l     = 1'b0;
        oe_a_l     = 1'b0;
        addr_a     = P_BASE + 12'd16;
        cs_b_l     = 1'b0;
        oe_b_l     = 1'b0;
        addr_b     = P_BASE + 12'd17;
        state_next = FIN_LAT;
      end
      FIN_LAT: state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Keep the SRAM deselected while reset is held, before the state settles.
    if (reset) begin
      done   = 1'b0;
      cs_a_l = 1'b1;
      oe_a_l = 1'b1;
      addr_a = '0;
      cs_b_l = 1'b1;
      oe_b_l = 1'b1;
      addr_b = '0;
    end
  end

  // Feistel datapath: operand capture, round updates and final whitening.
  always_ff @(posedge clk) begin
    if (reset) begin
      round   <= '0;
      xl      <= '0;
      xr      <= '0;
      t       <= '0;
      resultl <= '0;
      resultr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          xl    <= datal;
          xr    <= datar;
          round <= '0;
        end
        P_LAT:   xl <= xl ^ data_a;
        S01_LAT: t  <= data_a + data_b;
        S23_LAT: begin
          xl    <= xr ^ f;
          xr    <= xl;
          round <= round + 4'd1;
        end
        // The last round's swap is undone by crossing the halves here.
        FIN_LAT: begin
          resultr <= xl ^ data_a;
          resultl <= xr ^ data_b;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blowfish_feistel.sv
// Self-checking bench for blowfish_feistel: behavioural SRAM, reference
// Blowfish model, and a scoreboard of expected ciphertexts.
module tb_blowfish_feistel;

  localparam int P_OFF = 4000;
  localparam int S_OFF = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] datal = '0;
  logic [31:0] datar = '0;
  logic [31:0] resultl, resultr;
  logic        done;
  logic [11:0] addr_a, addr_b;
  logic        cs_a_l, cs_b_l, oe_a_l, oe_b_l, we_a_l, we_b_l;
  wire  [31:0] data_a, data_b;

  logic [31:0] mem [0:4095];
  logic [31:0] rd_a = '0, rd_b = '0;
  logic        en_a = 1'b0, en_b = 1'b0;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
  } res_t;
  res_t sb[$];

  typedef struct {
    logic [31:0] l, r, p16, p17, exp_l, exp_r;
  } vec_t;

  int passed = 0;
  int total  = 0;
  int viol   = 0;

  blowfish_feistel #(.P_ARRAY_OFFSET(P_OFF), .SBOX_OFFSET(S_OFF)) dut (
    .clk(clk), .reset(reset), .start(start), .datal(datal), .datar(datar),
    .resultl(resultl), .resultr(resultr), .done(done),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .cs_a_l(cs_a_l), .cs_b_l(cs_b_l), .oe_a_l(oe_a_l), .oe_b_l(oe_b_l),
    .we_a_l(we_a_l), .we_b_l(we_b_l)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: address in cycle N, data on the bus during cycle N+1.
  always @(posedge clk) begin
    en_a <= !cs_a_l && !oe_a_l;
    en_b <= !cs_b_l && !oe_b_l;
    rd_a <= mem[addr_a];
    rd_b <= mem[addr_b];
  end
  assign data_a = en_a ? rd_a : 'z;
  assign data_b = en_b ? rd_b : 'z;

  // Bus rules that must hold on every cycle.
  always @(negedge clk) begin
    if (we_a_l !== 1'b1 || we_b_l !== 1'b1) viol++;
    if (cs_a_l === 1'b1 && (oe_a_l !== 1'b1 || addr_a !== 12'd0)) viol++;
    if (cs_b_l === 1'b1 && (oe_b_l !== 1'b1 || addr_b !== 12'd0)) viol++;
    if (reset && (cs_a_l !== 1'b1 || cs_b_l !== 1'b1)) viol++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation ran past 1ms, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] bf_f(input logic [31:0] x);
    logic [31:0] h;
    h = mem[S_OFF + int'(x[31:24])] + mem[S_OFF + 256 + int'(x[23:16])];
    h = h ^ mem[S_OFF + 512 + int'(x[15:8])];
    return h + mem[S_OFF + 768 + int'(x[7:0])];
  endfunction

  // Textbook Blowfish encipher; returns {left, right}.
  function automatic logic [63:0] bf_model(input logic [31:0] l, input logic [31:0] r);
    logic [31:0] a, b, tmp;
    a = l;
    b = r;
    for (int i = 0; i < 16; i++) begin
      a   = a ^ mem[P_OFF + i];
      b   = b ^ bf_f(a);
      tmp = a; a = b; b = tmp;
    end
    tmp = a; a = b; b = tmp;
    b = b ^ mem[P_OFF + 16];
    a = a ^ mem[P_OFF + 17];
    return {a, b};
  endfunction

  task automatic push_exp(input logic [31:0] el, input logic [31:0] er);
    res_t e;
    e.l = el;
    e.r = er;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string name);
    res_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(name, {resultl, resultr}, {e.l, e.r});
    end
  endtask

  task automatic no_done(input int cycles, input string name);
    int cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check(name, 64'(cnt), 64'd0);
  endtask

  // Drive one block; optional start pulses during the rounds and during DONE.
  task automatic run_block(input string name, input logic [31:0] l, input logic [31:0] r,
                           input logic [31:0] el, input logic [31:0] er,
                           input int pulse_at, input bit pulse_done);
    int n;
    push_exp(el, er);
    @(negedge clk);
    datal = l; datar = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0; datal = $urandom; datar = $urandom;
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == pulse_at);
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(n), 64'd99);
    pop_cmp({name, "_result"});
    if (pulse_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      no_done(120, {name, "_start_in_done_ignored"});
      check({name, "_result_held"}, {resultl, resultr}, {el, er});
    end
  endtask

  initial begin
    vec_t        vecs[4];
    logic [63:0] m;
    logic [31:0] l, r;
    int          n;

    for (int i = 0; i < 4096; i++) mem[i] = '0;

    vecs[0] = '{32'h01234567, 32'h89ABCDEF, 32'h0,        32'h0,        32'h89ABCDEF, 32'h01234567};
    vecs[1] = '{32'h01234567, 32'h89ABCDEF, 32'hAAAAAAAA, 32'h55555555, 32'hDCFE98BA, 32'hAB89EFCD};
    vecs[2] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'hFFFFFFFF};
    vecs[3] = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h0,        32'h0,        32'hCAFEBABE, 32'hDEADBEEF};

    repeat (3) @(negedge clk);
    check("reset_result", {resultl, resultr}, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_cs_oe", {60'd0, cs_a_l, cs_b_l, oe_a_l, oe_b_l}, 64'hF);
    check("reset_addr", {40'd0, addr_a, addr_b}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cs", {62'd0, cs_a_l, cs_b_l}, 64'h3);

    // Table vectors with all-zero S-boxes: only the final whitening matters.
    for (int v = 0; v < 4; v++) begin
      mem[P_OFF + 16] = vecs[v].p16;
      mem[P_OFF + 17] = vecs[v].p17;
      run_block($sformatf("vec%0d", v), vecs[v].l, vecs[v].r, vecs[v].exp_l, vecs[v].exp_r,
                (v == 3) ? 40 : 0, 1'b0);
    end
    mem[P_OFF + 16] = '0;
    mem[P_OFF + 17] = '0;

    // P[0] steers the first S-box lookup.
    mem[P_OFF] = 32'h01000000;
    push_exp(32'h00000000, 32'h01000000);
    @(negedge clk);
    datal = '0; datar = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("p_rd_addr", {40'd0, addr_a, addr_b}, {40'd0, 12'(P_OFF), 12'd0});
    check("p_rd_cs", {62'd0, cs_a_l, cs_b_l}, 64'h1);
    repeat (2) @(negedge clk);
    check("s01_addr", {40'd0, addr_a, addr_b}, {40'd0, 12'(S_OFF + 1), 12'(S_OFF + 256)});
    check("s01_cs", {62'd0, cs_a_l, cs_b_l}, 64'h0);
    n = 3;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("p0_latency", 64'(n), 64'd99);
    pop_cmp("p0_result");

    // Random key material from here on.
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;

    l = $urandom; r = $urandom; m = bf_model(l, r);
    run_block("rnd_pulse", l, r, m[63:32], m[31:0], 25, 1'b1);

    // Reset mid-block aborts it.
    @(negedge clk);
    datal = $urandom; datar = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_cs", {62'd0, cs_a_l, cs_b_l}, 64'h3);
    check("abort_result_cleared", {resultl, resultr}, 64'd0);
    no_done(120, "abort_no_done");
    l = $urandom; r = $urandom; m = bf_model(l, r);
    run_block("after_abort", l, r, m[63:32], m[31:0], 0, 1'b0);

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    no_done(120, "reset_beats_start");

    // Start held high: back-to-back blocks every 100 cycles.
    @(negedge clk);
    l = $urandom; r = $urandom; m = bf_model(l, r);
    push_exp(m[63:32], m[31:0]);
    datal = l; datar = r; start = 1'b1;
    for (int b = 0; b < 200; b++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 300);
      check("held_period", 64'(n), (b == 0) ? 64'd99 : 64'd100);
      pop_cmp("held_result");
      if (b < 199) begin
        l = $urandom; r = $urandom; m = bf_model(l, r);
        push_exp(m[63:32], m[31:0]);
        datal = l; datar = r;
      end else begin
        start = 1'b0;
      end
    end
    repeat (5) @(negedge clk);

    check("bus_invariants", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
